bound_flasher_param: RTL and testbench

- Parametrised successor to the 16-LED bound flasher. Drives an N-wide thermometer LED bar through a six-phase up/down sequence with configurable bounds.
- Triggered by `flick`. Supports kickback on `flick` at the intermediate bounds.
- New versus the fixed block: a programmable step prescaler, an auto-repeat mode, and busy/phase status outputs.
- Sits between the board push-button synchroniser and the LED pins.

---
 rtl/bound_flasher_param_if.sv | 39 +++
 rtl/bound_flasher_param.sv | 172 +++++++++++++++++
 tb/tb_bound_flasher_param.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bound_flasher_param_if.sv
`default_nettype none
// ============================================================================
// Module   : bound_flasher_param_if
// Purpose  : Request/status bundle between the push-button side and the
//            bound flasher.
//   flick       : start / kickback request (synchronised, level-sampled)
//   auto_repeat : restart the sequence instead of idling at the end
//   leds        : thermometer LED bar, NUM_LEDS wide
//   busy        : high whenever the flasher is not idle
//   phase       : current phase code (IDLE=0 .. DN3=6)
// Modports : master drives the requests, slave is the flasher side.
// Revision : 1.0 - initial release
// ============================================================================
interface bound_flasher_param_if #(
  parameter int NUM_LEDS = 16
);
  logic                flick;
  logic                auto_repeat;
  logic [NUM_LEDS-1:0] leds;
  logic                busy;
  logic [2:0]          phase;

  modport master (
    output flick,
    output auto_repeat,
    input  leds,
    input  busy,
    input  phase
  );

  modport slave (
    input  flick,
    input  auto_repeat,
    output leds,
    output busy,
    output phase
  );
endinterface
`default_nettype wire

// File: rtl/bound_flasher_param.sv
`default_nettype none
// ============================================================================
// Module   : bound_flasher_param
// Purpose  : Parametrised bound flasher. Walks an N-wide thermometer LED bar
//            through UP1/DN1/UP2/DN2/UP3/DN3 with kickback on flick at the
//            intermediate bounds, a step prescaler and optional auto-repeat.
// Ports    :
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - bound_flasher_param_if.slave (flick, auto_repeat in;
//          leds, busy, phase out; all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module bound_flasher_param #(
  parameter int NUM_LEDS = 16,
  parameter int T1       = 6,
  parameter int T2       = 11,
  parameter int T_LO     = 5,
  parameter int STEP_DIV = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  bound_flasher_param_if.slave bus
);

  localparam int c_LW = $clog2(NUM_LEDS + 1);
  localparam int c_PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_UP1  = 3'd1;
  localparam logic [2:0] c_DN1  = 3'd2;
  localparam logic [2:0] c_UP2  = 3'd3;
  localparam logic [2:0] c_DN2  = 3'd4;
  localparam logic [2:0] c_UP3  = 3'd5;
  localparam logic [2:0] c_DN3  = 3'd6;

  localparam logic [c_LW-1:0] c_T1   = c_LW'(T1);
  localparam logic [c_LW-1:0] c_T2   = c_LW'(T2);
  localparam logic [c_LW-1:0] c_TLO  = c_LW'(T_LO);
  localparam logic [c_LW-1:0] c_TOP  = c_LW'(NUM_LEDS);
  localparam logic [c_PW-1:0] c_PMAX = c_PW'(STEP_DIV - 1);

  // Bounds must nest strictly inside the bar, otherwise the sequence
  // could never reach its turning points.
  if (!(0 < T_LO && T_LO < T1 && T1 < T2 && T2 < NUM_LEDS && STEP_DIV >= 1)) begin : g_param_check
    $error("bound_flasher_param: illegal NUM_LEDS/T1/T2/T_LO/STEP_DIV combination");
  end

  logic [2:0]          state_q, state_d;
  logic [c_LW-1:0]     lit_q, lit_d;
  logic [c_PW-1:0]     pre_q, pre_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                busy_q, busy_d;

  logic                w_tick;
  logic [c_LW-1:0]     w_inc;
  logic [c_LW-1:0]     w_dec;

  assign w_tick = (state_q != c_IDLE) && (pre_q == c_PMAX);
  assign w_inc  = lit_q + c_LW'(1);
  assign w_dec  = lit_q - c_LW'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      lit_q   <= '0;
      pre_q   <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lit_q   <= lit_d;
      pre_q   <= pre_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Transitions are decided on the post-step lit count,
  // so a bound reached on a tick turns the sequence on that same edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lit_d   = lit_q;
    pre_d   = pre_q;

    // Prescaler idles at zero, so entry from IDLE always starts a full step.
    if (state_q == c_IDLE || w_tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + c_PW'(1);
    end

    case (state_q)
      c_IDLE: begin
        if (bus.flick || bus.auto_repeat) begin
          state_d = c_UP1;
        end
      end
      c_UP1: begin
        if (w_tick) begin
          lit_d = w_inc;
          if (w_inc == c_T1) state_d = c_DN1;
        end
      end
      c_DN1: begin
        if (w_tick) begin
          lit_d = w_dec;
          if (w_dec == '0) state_d = c_UP2;
        end
      end
      c_UP2: begin
        if (w_tick) begin
          lit_d = w_inc;
          if (w_inc == c_T2) begin
            state_d = bus.flick ? c_DN1 : c_DN2;
          end else if (w_inc == c_T1 && bus.flick) begin
            state_d = c_DN1;
          end
        end
      end
      c_DN2: begin
        if (w_tick) begin
          lit_d = w_dec;
          if (w_dec == c_TLO) state_d = c_UP3;
        end
      end
      c_UP3: begin
        if (w_tick) begin
          lit_d = w_inc;
          if (w_inc == c_TOP) begin
            state_d = c_DN3;
          end else if ((w_inc == c_T1 || w_inc == c_T2) && bus.flick) begin
            state_d = c_DN2;
          end
        end
      end
      c_DN3: begin
        if (w_tick) begin
          lit_d = w_dec;
          if (w_dec == '0) state_d = bus.auto_repeat ? c_UP1 : c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
        lit_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: computed from next-state values and registered alongside
  // the state so every output is a flop.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d != c_IDLE);
    leds_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = (int'(lit_d) > i);
    end
  end

  assign bus.leds  = leds_q;
  assign bus.busy  = busy_q;
  assign bus.phase = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_bound_flasher_param
// Purpose  : Self-checking bench. Two flashers (STEP_DIV=1 and STEP_DIV=4)
//            share one stimulus stream; a phase-goal model predicts both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bound_flasher_param;
  localparam int N    = 16;
  localparam int T1   = 6;
  localparam int T2   = 11;
  localparam int T_LO = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flick = 1'b0;
  logic ar    = 1'b0;

  int total = 0;
  int bad   = 0;

  bound_flasher_param_if #(.NUM_LEDS(N)) bus0 ();
  bound_flasher_param_if #(.NUM_LEDS(N)) bus1 ();

  assign bus0.flick       = flick;
  assign bus0.auto_repeat = ar;
  assign bus1.flick       = flick;
  assign bus1.auto_repeat = ar;

  bound_flasher_param #(.NUM_LEDS(N), .T1(T1), .T2(T2), .T_LO(T_LO), .STEP_DIV(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bound_flasher_param #(.NUM_LEDS(N), .T1(T1), .T2(T2), .T_LO(T_LO), .STEP_DIV(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each phase walks towards a goal count; odd phases count up, even down.
  int m_lit [2] = '{0, 0};
  int m_ph  [2] = '{0, 0};
  int m_div [2] = '{0, 0};

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int goal_of(input int ph);
    case (ph)
      1: return T1;
      2: return 0;
      3: return T2;
      4: return T_LO;
      5: return N;
      default: return 0;
    endcase
  endfunction

  function automatic logic [N-1:0] therm(input int l);
    logic [N:0] t;
    t = (17'd1 << l) - 17'd1;
    return t[N-1:0];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_lit[k] = 0; m_ph[k] = 0; m_div[k] = 0;
      end else if (m_ph[k] == 0) begin
        if (flick || ar) begin
          m_ph[k] = 1; m_div[k] = 0;
        end
      end else if (m_div[k] == div_of(k) - 1) begin
        m_div[k] = 0;
        m_lit[k] = m_lit[k] + ((m_ph[k] % 2 == 1) ? 1 : -1);
        if (m_lit[k] == goal_of(m_ph[k])) begin
          case (m_ph[k])
            3:       m_ph[k] = flick ? 2 : 4;
            6:       m_ph[k] = ar ? 1 : 0;
            default: m_ph[k] = m_ph[k] + 1;
          endcase
        end else if (flick && ((m_ph[k] == 3 && m_lit[k] == T1) ||
                               (m_ph[k] == 5 && (m_lit[k] == T1 || m_lit[k] == T2)))) begin
          m_ph[k] = m_ph[k] - 1;   // kickback to the preceding descent
        end
      end else begin
        m_div[k] = m_div[k] + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance to the falling edge and compare both DUTs to the model.
  task automatic step();
    @(negedge clk);
    chk("dut0 leds",  int'(bus0.leds),  int'(therm(m_lit[0])));
    chk("dut0 busy",  int'(bus0.busy),  (m_ph[0] != 0) ? 1 : 0);
    chk("dut0 phase", int'(bus0.phase), m_ph[0]);
    chk("dut1 leds",  int'(bus1.leds),  int'(therm(m_lit[1])));
    chk("dut1 busy",  int'(bus1.busy),  (m_ph[1] != 0) ? 1 : 0);
    chk("dut1 phase", int'(bus1.phase), m_ph[1]);
  endtask

  // Literal expectation on dut0 that also pins the model.
  task automatic pin(input string name, input int ph, input int lv);
    chk({name, " dut phase"},   int'(bus0.phase),       ph);
    chk({name, " dut leds"},    int'(bus0.leds),        lv);
    chk({name, " model phase"}, m_ph[0],                ph);
    chk({name, " model leds"},  int'(therm(m_lit[0])),  lv);
  endtask

  task automatic wait_until(input string name, input int ph, input int lv, input int maxc);
    int n = 0;
    while (!(int'(bus0.phase) == ph && int'(bus0.leds) == lv) && n < maxc) begin
      step();
      n++;
    end
    chk({name, " reached"}, (n < maxc) ? 1 : 0, 1);
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int marks [$];
    int idle_seen, run, run_bad, prev_ph, hi_ph, over, saw_top;
    logic [N-1:0] prev_leds;

    reset_seq();
    chk("reset leds",  int'(bus0.leds),  0);
    chk("reset busy",  int'(bus0.busy),  0);
    chk("reset phase", int'(bus0.phase), 0);

    // Full nominal run from a one-cycle flick pulse.
    flick = 1'b1;
    step();
    flick = 1'b0;
    cnt = 0;
    while (bus0.busy && cnt < 200) begin
      cnt++;
      if (cnt == 7)  pin("t1 UP1 peak",  2, 'h003F);
      if (cnt == 13) pin("t1 DN1 floor", 3, 'h0000);
      if (cnt == 24) pin("t1 UP2 peak",  4, 'h07FF);
      if (cnt == 30) pin("t1 DN2 floor", 5, 'h001F);
      if (cnt == 41) pin("t1 UP3 peak",  6, 'hFFFF);
      step();
    end
    // busy rises on the start edge and falls on the 57th edge of the run.
    chk("t1 busy edges", cnt + 1, 57);
    chk("t1 end phase", int'(bus0.phase), 0);

    // Kickback in UP2 at T1, then a clean UP2 to T2.
    reset_seq();
    flick = 1'b1;
    step();
    flick = 1'b0;
    wait_until("t2 UP2 at 5", 3, 'h001F, 100);
    flick = 1'b1;
    step();
    flick = 1'b0;
    pin("t2 kickback", 2, 'h003F);
    wait_until("t2 back to UP2", 3, 'h0000, 100);
    wait_until("t2 UP2 peak", 4, 'h07FF, 100);

    // Kickback in UP3 at T2.
    wait_until("t3 UP3 at 10", 5, 'h03FF, 100);
    flick = 1'b1;
    step();
    flick = 1'b0;
    pin("t3 kickback", 4, 'h07FF);
    wait_until("t3 DN2 floor", 5, 'h001F, 100);
    wait_until("t3 UP3 peak", 6, 'hFFFF, 100);

    // Reset mid-UP3 with flick held through it.
    reset_seq();
    flick = 1'b1;
    step();
    flick = 1'b0;
    wait_until("t4 UP3 at 9", 5, 'h01FF, 100);
    rst   = 1'b1;
    flick = 1'b1;
    step();
    pin("t4 reset", 0, 'h0000);
    chk("t4 reset busy", int'(bus0.busy), 0);
    rst = 1'b0;
    step();
    pin("t4 restart", 1, 'h0000);
    flick = 1'b0;

    // Auto-repeat on the STEP_DIV=4 instance.
    ar = 1'b1;
    reset_seq();
    idle_seen = 0; run = 0; run_bad = 0;
    prev_ph   = int'(bus1.phase);
    prev_leds = bus1.leds;
    for (int i = 0; i < 800 && marks.size() < 2; i++) begin
      step();
      if (!bus1.busy) idle_seen++;
      if (marks.size() == 1) begin
        if (bus1.leds == prev_leds) begin
          run++;
        end else begin
          if (run != 3) run_bad++;
          run = 0;
        end
      end
      if (prev_ph == 6 && int'(bus1.phase) == 1) begin
        marks.push_back(i);
        run = 0;
      end
      prev_ph   = int'(bus1.phase);
      prev_leds = bus1.leds;
    end
    chk("t5 wraps seen", marks.size(), 2);
    if (marks.size() == 2) chk("t5 period", marks[1] - marks[0], 224);
    chk("t5 idle cycles", idle_seen, 0);
    chk("t5 hold violations", run_bad, 0);
    ar = 1'b0;

    // Constant flick: loops UP2<->DN1 forever.
    reset_seq();
    flick = 1'b1;
    hi_ph = 0; over = 0; saw_top = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (int'(bus0.phase) >= 4 || int'(bus1.phase) >= 4) hi_ph++;
      if (int'(bus0.leds) > 'h3F || int'(bus1.leds) > 'h3F) over++;
      if (int'(bus0.leds) == 'h3F) saw_top++;
    end
    chk("t6 late phases", hi_ph, 0);
    chk("t6 above T1", over, 0);
    chk("t6 reached T1", (saw_top > 0) ? 1 : 0, 1);
    flick = 1'b0;

    // Random traffic against the model.
    reset_seq();
    for (int i = 0; i < 3000; i++) begin
      flick = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) ar = ~ar;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
